// File: rtl/pe_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_if
// Description : Host/program-load and pe-control bundle for the pe_seq
//               microcode sequencer.
//               master : host side. Drives prog_we/prog_addr/prog_data/start
//                        (and step when PE_SEQ_STEP_EN is defined). Observes
//                        busy/done/pc_o and the pe controls.
//               slave  : sequencer side.
//               Optional feature macro: PE_SEQ_STEP_EN adds the 1-bit step
//               input.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_seq_if #(
    parameter int PC_W = 5
);
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [19:0]     prog_data;
    logic            start;
`ifdef PE_SEQ_STEP_EN
    logic            step;
`endif
    logic            busy;
    logic            done;
    logic [PC_W-1:0] pc_o;
    logic [2:0]      w;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [2:0]      src;
    logic [2:0]      op;
    logic            imm;
    logic            re;

    modport master (
        output prog_we, prog_addr, prog_data, start,
`ifdef PE_SEQ_STEP_EN
        output step,
`endif
        input  busy, done, pc_o, w, ra, rb, src, op, imm, re
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start,
`ifdef PE_SEQ_STEP_EN
        input  step,
`endif
        output busy, done, pc_o, w, ra, rb, src, op, imm, re
    );
endinterface
`default_nettype wire

// File: rtl/pe_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq
// Description : Microcode sequencer feeding the SIMD pe array. It holds a
//               PROG_DEPTH-entry program of 20-bit words and issues one
//               registered control set per cycle. It supports counted loops
//               (SETLOOP/BNZ) and HALT.
//               Ports  : clk, rst (async, active-high), bus (pe_seq_if.slave)
//                        bus inputs : prog_we, prog_addr, prog_data, start
//                                     (+ step with PE_SEQ_STEP_EN)
//                        bus outputs: busy, done, pc_o, w, ra, rb, src, op,
//                                     imm, re
//               Word   : [2:0]w [5:3]ra [8:6]rb [11:9]src [14:12]op [15]imm
//                        [16]re [17]rsvd [19:18]ctl
//               Option : PE_SEQ_STEP_EN - RUN advances only when step=1.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_seq #(
    parameter int PROG_DEPTH = 32,
    parameter int PC_W       = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
    parameter int LOOP_W     = 8
) (
    input wire      clk,
    input wire      rst,
    pe_seq_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_CTL_EXEC    = 2'b00;
    localparam logic [1:0] c_CTL_SETLOOP = 2'b01;
    localparam logic [1:0] c_CTL_BNZ     = 2'b10;
    localparam logic [1:0] c_CTL_HALT    = 2'b11;

    // Control bundle layout matches word[16:0]: {re, imm, op, src, rb, ra, w}.
    // NOP selects the constant-0 source so the pe array sees no data change.
    localparam logic [16:0] c_NOP_CTRL = {1'b0, 1'b0, 3'd0, 3'b111, 3'd0, 3'd0, 3'd0};

    localparam logic [PC_W-1:0] c_PC_LAST    = PC_W'(PROG_DEPTH - 1);
    localparam logic [PC_W:0]   c_DEPTH_EXT  = (PC_W + 1)'(PROG_DEPTH);

    logic [19:0]       r_mem [PROG_DEPTH];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_pc_inc;
    logic [LOOP_W-1:0] r_lc;
    logic [LOOP_W-1:0] w_lc_nxt;
    logic [16:0]       r_ctrl;
    logic [16:0]       w_ctrl_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic [19:0]       w_word;
    logic              w_mem_we;
    logic              w_adv;
    logic              w_unused_rsvd;

`ifdef PE_SEQ_STEP_EN
    assign w_adv = bus.step;
`else
    assign w_adv = 1'b1;
`endif

    // Writes are only accepted while idle so a running program is never
    // modified underneath itself; out-of-range addresses are dropped.
    assign w_mem_we = (r_state == c_ST_IDLE) && bus.prog_we &&
                      ({1'b0, bus.prog_addr} < c_DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign w_word        = r_mem[r_pc];
    assign w_unused_rsvd = w_word[17];
    assign w_pc_inc      = (r_pc == c_PC_LAST) ? '0 : r_pc + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lc_nxt    = r_lc;
        w_ctrl_nxt  = c_NOP_CTRL;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_RUN;
                    w_pc_nxt    = '0;
                end
            end
            c_ST_RUN: begin
                // A stalled cycle keeps pc/lc and issues NOP so the pe
                // registers are not rewritten with a repeated word.
                if (w_adv) begin
                    case (w_word[19:18])
                        c_CTL_EXEC: begin
                            w_ctrl_nxt = w_word[16:0];
                            w_pc_nxt   = w_pc_inc;
                        end
                        c_CTL_SETLOOP: begin
                            w_lc_nxt = w_word[LOOP_W-1:0];
                            w_pc_nxt = w_pc_inc;
                        end
                        c_CTL_BNZ: begin
                            if (r_lc != '0) begin
                                w_lc_nxt = r_lc - 1'b1;
                                w_pc_nxt = w_word[PC_W-1:0];
                            end else begin
                                w_pc_nxt = w_pc_inc;
                            end
                        end
                        c_CTL_HALT: begin
                            w_state_nxt = c_ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                        default: begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    endcase
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_pc    <= '0;
            r_lc    <= '0;
            r_ctrl  <= c_NOP_CTRL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_lc    <= w_lc_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.busy = (r_state != c_ST_IDLE);
    assign bus.done = r_done;
    assign bus.pc_o = r_pc;
    assign bus.w    = r_ctrl[2:0];
    assign bus.ra   = r_ctrl[5:3];
    assign bus.rb   = r_ctrl[8:6];
    assign bus.src  = r_ctrl[11:9];
    assign bus.op   = r_ctrl[14:12];
    assign bus.imm  = r_ctrl[15];
    assign bus.re   = r_ctrl[16];

endmodule
`default_nettype wire

// File: tb/tb_pe_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_seq
// Description : Self-checking bench for pe_seq. Expected per-cycle control
//               sets are queued when a run is started and popped one per
//               cycle as the sequencer issues them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_seq;

    localparam int c_DEPTH = 32;
    localparam int c_PC_W  = 5;
    localparam int c_NVEC  = 8;

    logic clk = 1'b0;
    logic rst;

    pe_seq_if #(.PC_W(c_PC_W)) bus ();

    pe_seq #(
        .PROG_DEPTH (c_DEPTH),
        .PC_W       (c_PC_W),
        .LOOP_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] w;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] src;
        logic [2:0] op;
        logic       imm;
        logic       re;
        logic       done;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [19:0] word;
        exp_t        exp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[c_NVEC];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [19:0] f_exec(input logic [2:0] w, ra, rb, src, op,
                                           input logic imm, re);
        return {2'b00, 1'b0, re, imm, op, src, rb, ra, w};
    endfunction

    function automatic logic [19:0] f_setloop(input logic [7:0] n);
        return {2'b01, 10'd0, n};
    endfunction

    function automatic logic [19:0] f_bnz(input logic [4:0] t);
        return {2'b10, 13'd0, t};
    endfunction

    function automatic logic [19:0] f_halt();
        return {2'b11, 18'd0};
    endfunction

    function automatic exp_t f_ctl(input logic [2:0] w, ra, rb, src, op,
                                   input logic imm, re, done, busy);
        exp_t e;
        e.w = w; e.ra = ra; e.rb = rb; e.src = src; e.op = op;
        e.imm = imm; e.re = re; e.done = done; e.busy = busy;
        return e;
    endfunction

    function automatic exp_t f_nop(input logic done, busy);
        return f_ctl(3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, done, busy);
    endfunction

    task automatic check_ctl(input string name, input exp_t e);
        n_checks++;
        if (bus.w !== e.w || bus.ra !== e.ra || bus.rb !== e.rb ||
            bus.src !== e.src || bus.op !== e.op || bus.imm !== e.imm ||
            bus.re !== e.re || bus.done !== e.done || bus.busy !== e.busy) begin
            n_errors++;
            $display("FAIL %s: got w=%0d ra=%0d rb=%0d src=%0d op=%0d imm=%b re=%b done=%b busy=%b, expected w=%0d ra=%0d rb=%0d src=%0d op=%0d imm=%b re=%b done=%b busy=%b",
                     name, bus.w, bus.ra, bus.rb, bus.src, bus.op, bus.imm, bus.re,
                     bus.done, bus.busy, e.w, e.ra, e.rb, e.src, e.op, e.imm, e.re,
                     e.done, e.busy);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_word(input int addr, input logic [19:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr[c_PC_W-1:0];
        bus.prog_data = data;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    // Start a run and compare one queued entry per cycle. At cycle index
    // disturb_at a start pulse and a write of HALT to address 0 are driven.
    task automatic run_q(input string name, input int disturb_at);
        int   idx;
        exp_t e;
        idx = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            check_ctl($sformatf("%s[%0d]", name, idx), e);
            if (idx == disturb_at) begin
                bus.start     = 1'b1;
                bus.prog_we   = 1'b1;
                bus.prog_addr = '0;
                bus.prog_data = f_halt();
            end else begin
                bus.start   = 1'b0;
                bus.prog_we = 1'b0;
            end
            idx++;
            @(negedge clk);
        end
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
    endtask

    task automatic load_loop_prog();
        write_word(0, f_setloop(8'd3));
        write_word(1, f_exec(3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0));
        write_word(2, f_bnz(5'd1));
        write_word(3, f_halt());
    endtask

    task automatic push_loop_exp();
        q.push_back(f_nop(1'b0, 1'b1));          // start accepted
        q.push_back(f_nop(1'b0, 1'b1));          // SETLOOP
        for (int i = 0; i < 4; i++) begin
            q.push_back(f_ctl(3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            q.push_back(f_nop(1'b0, 1'b1));      // BNZ
        end
        q.push_back(f_nop(1'b1, 1'b1));          // HALT -> done pulse
        q.push_back(f_nop(1'b0, 1'b0));          // back in IDLE
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] w0;
        logic [19:0] wrd;
        exp_t        e;

        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
`ifdef PE_SEQ_STEP_EN
        bus.step      = 1'b1;
`endif
        rst = 1'b1;

        // Single-instruction vectors: {word at addr 0, control set it issues}
        vecs[0].word = f_exec(3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
        vecs[0].exp  = f_ctl (3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1].word = f_exec(3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        vecs[1].exp  = f_ctl (3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[2].word = f_exec(3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0);
        vecs[2].exp  = f_ctl (3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3].word = f_exec(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1);
        vecs[3].exp  = f_ctl (3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[4].word = f_exec(3'd5, 3'd2, 3'd6, 3'd1, 3'd3, 1'b0, 1'b1);
        vecs[4].exp  = f_ctl (3'd5, 3'd2, 3'd6, 3'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[5].word = f_setloop(8'd9);
        vecs[5].exp  = f_nop(1'b0, 1'b1);
        vecs[6].word = f_bnz(5'd1);              // either path lands on addr 1
        vecs[6].exp  = f_nop(1'b0, 1'b1);
        vecs[7].word = f_exec(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        vecs[7].exp  = f_ctl (3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        check_ctl("reset_state", f_nop(1'b0, 1'b0));
        check_val("reset_pc", int'(bus.pc_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: word written in the same cycle as start must be the one run.
        write_word(1, f_halt());
        for (int i = 0; i < c_NVEC; i++) begin
            q.push_back(f_nop(1'b0, 1'b1));
            q.push_back(vecs[i].exp);
            q.push_back(f_nop(1'b1, 1'b1));
            q.push_back(f_nop(1'b0, 1'b0));
            bus.prog_we   = 1'b1;
            bus.prog_addr = '0;
            bus.prog_data = vecs[i].word;
            run_q($sformatf("vec%0d", i), -1);
        end

        // Four-word program, with start + prog_we pulsed mid-run.
        w0 = f_exec(3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
        write_word(0, w0);
        write_word(1, f_exec(3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1));
        write_word(2, f_exec(3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0));
        write_word(3, f_halt());
        q.push_back(f_nop(1'b0, 1'b1));
        q.push_back(f_ctl(3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(f_ctl(3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        q.push_back(f_ctl(3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        q.push_back(f_nop(1'b1, 1'b1));
        q.push_back(f_nop(1'b0, 1'b0));
        run_q("prog4", 2);
        check_val("mem0_after_busy_write", int'(dut.r_mem[0]), int'(w0));

`ifdef PE_SEQ_STEP_EN
        // Step pattern 1,0,0,1 after start: two words issued, pc held.
        begin
            logic [3:0] pat;
            int         exp_pc[4];
            pat = 4'b1001;                       // pat[0] applies first
            exp_pc[0] = 1; exp_pc[1] = 1; exp_pc[2] = 1; exp_pc[3] = 2;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                bus.step = pat[k];
                @(negedge clk);
                if (k == 0)
                    e = f_ctl(3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
                else if (k == 3)
                    e = f_ctl(3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
                else
                    e = f_nop(1'b0, 1'b1);
                check_ctl($sformatf("step_ctl%0d", k), e);
                check_val($sformatf("step_pc%0d", k), int'(bus.pc_o), exp_pc[k]);
            end
            bus.step = 1'b1;
            repeat (4) @(negedge clk);
            check_ctl("step_end_idle", f_nop(1'b0, 1'b0));
        end
`endif

        // Counted loop: body runs n+1 = 4 times.
        load_loop_prog();
        push_loop_exp();
        run_q("loop", -1);
        check_val("loop_lc_end", int'(dut.r_lc), 0);

        // No HALT anywhere: pc wraps 31 -> 0, then async reset mid-clock.
        for (int i = 0; i < c_DEPTH; i++) begin
            write_word(i, f_exec(i[2:0], {1'b0, i[4:3]}, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0));
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            wrd = 20'((k - 1) % c_DEPTH);
            e = f_ctl(wrd[2:0], {1'b0, wrd[4:3]}, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_ctl($sformatf("wrap_ctl%0d", k), e);
            check_val($sformatf("wrap_pc%0d", k), int'(bus.pc_o), k % c_DEPTH);
        end
        #2 rst = 1'b1;
        #1;
        check_ctl("async_rst_ctl", f_nop(1'b0, 1'b0));
        check_val("async_rst_pc", int'(bus.pc_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a loop, then restart from pc 0 with lc 0.
        load_loop_prog();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);               // SETLOOP, body, BNZ done
        check_val("midloop_lc", int'(dut.r_lc), 2);
        #2 rst = 1'b1;
        #1;
        check_val("midloop_rst_lc", int'(dut.r_lc), 0);
        check_val("midloop_rst_pc", int'(bus.pc_o), 0);
        check_ctl("midloop_rst_ctl", f_nop(1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ctl("midloop_no_done", f_nop(1'b0, 1'b0));
        push_loop_exp();
        run_q("loop_restart", -1);
        check_val("loop_restart_lc_end", int'(dut.r_lc), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
